stopwatch_core: RTL and testbench

//  Centisecond stopwatch that sits downstream of the clock generator.

---
 rtl/stopwatch_core.sv | 150 +++++++++++++++
 tb/tb_stopwatch_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - centisecond MM:SS:CC BCD stopwatch with lap hold and overflow saturation
module stopwatch_core #(
  parameter int TICK_BOTH_EDGES = 1,
  parameter int MAX_MIN         = 99
) (
  input  logic       MCLK,
  input  logic       RESET_IN,
  input  logic       TICK_IN,
  input  logic       BTN_SS,
  input  logic       BTN_LC,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_O,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_O,
  output logic [3:0] CS_T,
  output logic [3:0] CS_O,
  output logic       RUNNING,
  output logic       LAP_HOLD,
  output logic       OVERFLOW
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam logic [3:0]  MAX_MT   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_MO   = 4'(MAX_MIN % 10);
  localparam logic [23:0] CNT_MAX  = {MAX_MT, MAX_MO, 4'd5, 4'd9, 4'd9, 4'd9};

  state_t      state_q, state_d;
  logic        tick_q;
  logic        tick;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] disp_q, disp_d;
  logic [23:0] cnt_inc;
  logic        ovf_q, ovf_d;
  logic        run_q, run_d;
  logic        hold_q, hold_d;

  assign tick = (TICK_BOTH_EDGES != 0) ? (TICK_IN ^ tick_q) : (TICK_IN & ~tick_q);

  // Digit order is {min tens, min ones, sec tens, sec ones, cs tens, cs ones}.
  always_comb begin
    logic [3:0] mt, mo, st, so, ct, co;
    {mt, mo, st, so, ct, co} = cnt_q;
    if (co != 4'd9) begin
      co = co + 4'd1;
    end else begin
      co = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (so != 4'd9) begin
          so = so + 4'd1;
        end else begin
          so = 4'd0;
          if (st != 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if (mo != 4'd9) begin
              mo = mo + 4'd1;
            end else begin
              mo = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    cnt_inc = {mt, mo, st, so, ct, co};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;

    // The tick is applied in the current state before any button transition.
    if (tick && (state_q == RUN || state_q == LAP)) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    case (state_q)
      IDLE: begin
        if (BTN_SS) state_d = RUN;
      end
      RUN: begin
        if (BTN_SS) begin
          state_d = PAUSE;
        end else if (BTN_LC) begin
          state_d = LAP;
          lap_d   = cnt_q;
        end
      end
      LAP: begin
        if (BTN_SS)      state_d = PAUSE;
        else if (BTN_LC) state_d = RUN;
      end
      PAUSE: begin
        if (BTN_SS) begin
          state_d = RUN;
        end else if (BTN_LC) begin
          state_d = IDLE;
          cnt_d   = '0;
          lap_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    disp_d = (state_d == LAP) ? lap_d : cnt_d;
    run_d  = (state_d == RUN) || (state_d == LAP);
    hold_d = (state_d == LAP);
  end

  always_ff @(posedge MCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      lap_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= TICK_IN;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
    end
  end

  assign {MIN_T, MIN_O, SEC_T, SEC_O, CS_T, CS_O} = disp_q;
  assign RUNNING  = run_q;
  assign LAP_HOLD = hold_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core (MAX_MIN 99 and 1 instances)
module tb_stopwatch_core;

  logic MCLK = 1'b0;
  logic RESET_IN;
  logic tick0, ss0, lc0;
  logic tick1, ss1, lc1;
  wire [26:0] o0, o1;

  always #10 MCLK = ~MCLK;

  stopwatch_core #(.TICK_BOTH_EDGES(1), .MAX_MIN(99)) dut0 (
    .MCLK(MCLK), .RESET_IN(RESET_IN), .TICK_IN(tick0), .BTN_SS(ss0), .BTN_LC(lc0),
    .MIN_T(o0[26:23]), .MIN_O(o0[22:19]), .SEC_T(o0[18:15]), .SEC_O(o0[14:11]),
    .CS_T(o0[10:7]), .CS_O(o0[6:3]), .RUNNING(o0[2]), .LAP_HOLD(o0[1]), .OVERFLOW(o0[0])
  );

  stopwatch_core #(.TICK_BOTH_EDGES(1), .MAX_MIN(1)) dut1 (
    .MCLK(MCLK), .RESET_IN(RESET_IN), .TICK_IN(tick1), .BTN_SS(ss1), .BTN_LC(lc1),
    .MIN_T(o1[26:23]), .MIN_O(o1[22:19]), .SEC_T(o1[18:15]), .SEC_O(o1[14:11]),
    .CS_T(o1[10:7]), .CS_O(o1[6:3]), .RUNNING(o1[2]), .LAP_HOLD(o1[1]), .OVERFLOW(o1[0])
  );

  typedef struct {
    int          ch;
    logic [26:0] v;
    string       tag;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "reset";

  // Reference model: 0 idle, 1 run, 2 lap, 3 pause; count held as total centiseconds.
  int m_st[2];
  int m_cnt[2];
  int m_lap[2];
  int m_ovf[2];
  int m_max[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [26:0] exp_vec(input int ch);
    int d, m, s, c;
    d = (m_st[ch] == 2) ? m_lap[ch] : m_cnt[ch];
    m = d / 6000;
    s = (d / 100) % 60;
    c = d % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10),
            (m_st[ch] == 1 || m_st[ch] == 2), (m_st[ch] == 2), (m_ovf[ch] != 0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int ch, input bit s, input bit l, input bit t);
    int pre;
    pre = m_cnt[ch];
    if (t && (m_st[ch] == 1 || m_st[ch] == 2)) begin
      if (m_cnt[ch] == m_max[ch]) m_ovf[ch] = 1;
      else m_cnt[ch] = m_cnt[ch] + 1;
    end
    case (m_st[ch])
      0: if (s) m_st[ch] = 1;
      1: if (s) m_st[ch] = 3;
         else if (l) begin m_st[ch] = 2; m_lap[ch] = pre; end
      2: if (s) m_st[ch] = 3;
         else if (l) m_st[ch] = 1;
      default: if (s) m_st[ch] = 1;
               else if (l) begin m_st[ch] = 0; m_cnt[ch] = 0; m_lap[ch] = 0; m_ovf[ch] = 0; end
    endcase
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, (e.ch == 0) ? o0 : o1, e.v);
    end
  endtask

  // Called at a negedge; drives one cycle of stimulus on one channel and checks its result.
  task automatic cyc(input int ch, input bit s, input bit l, input bit t);
    exp_t e;
    if (ch == 0) begin
      ss0 = s; lc0 = l; if (t) tick0 = ~tick0;
    end else begin
      ss1 = s; lc1 = l; if (t) tick1 = ~tick1;
    end
    model_step(ch, s, l, t);
    e.ch = ch; e.v = exp_vec(ch); e.tag = cur_tag;
    sb.push_back(e);
    @(posedge MCLK);
    @(negedge MCLK);
    ss0 = 1'b0; lc0 = 1'b0; ss1 = 1'b0; lc1 = 1'b0;
    sb_pop();
  endtask

  task automatic ticks(input int ch, input int n);
    for (int i = 0; i < n; i++) cyc(ch, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_max[0] = 99 * 6000 + 5999;
    m_max[1] = 1 * 6000 + 5999;
    model_reset();
    RESET_IN = 1'b1;
    tick0 = 1'b0; ss0 = 1'b0; lc0 = 1'b0;
    tick1 = 1'b0; ss1 = 1'b0; lc1 = 1'b0;
    repeat (3) @(negedge MCLK);
    check("reset_o0", {5'd0, o0}, 32'd0);
    check("reset_o1", {5'd0, o1}, 32'd0);
    RESET_IN = 1'b0;

    cur_tag = "idle_ticks";
    ticks(0, 4);
    cur_tag = "run150";
    cyc(0, 1'b1, 1'b0, 1'b0);
    ticks(0, 150);
    check("run150_disp", {8'd0, o0[26:3]}, 32'h000150);
    check("run150_running", {31'd0, o0[2]}, 32'd1);

    cur_tag = "run1234";
    ticks(0, 1084);
    check("run1234_disp", {8'd0, o0[26:3]}, 32'h001234);

    // Asynchronous reset mid-run, with TICK_IN high across the release.
    #3;
    RESET_IN = 1'b1;
    tick0 = 1'b1;
    #2;
    check("async_reset_o0", {5'd0, o0}, 32'd0);
    model_reset();
    @(negedge MCLK);
    RESET_IN = 1'b0;
    cur_tag = "post_reset";
    cyc(0, 1'b0, 1'b0, 1'b0);
    ticks(0, 5);
    check("post_reset_disp", {5'd0, o0}, 32'd0);

    cur_tag = "carry";
    cyc(0, 1'b1, 1'b0, 1'b0);
    ticks(0, 999);
    check("carry_0999", {8'd0, o0[26:3]}, 32'h000999);
    ticks(0, 1);
    check("carry_1000", {8'd0, o0[26:3]}, 32'h001000);
    ticks(0, 4999);
    check("carry_5999", {8'd0, o0[26:3]}, 32'h005999);
    ticks(0, 1);
    check("carry_10000", {8'd0, o0[26:3]}, 32'h010000);

    cur_tag = "clear";
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("clear_o0", {5'd0, o0}, 32'd0);

    cur_tag = "lap";
    cyc(0, 1'b1, 1'b0, 1'b0);
    ticks(0, 200);
    cyc(0, 1'b0, 1'b1, 1'b0);
    ticks(0, 300);
    check("lap_disp", {8'd0, o0[26:3]}, 32'h000200);
    check("lap_hold", {31'd0, o0[1]}, 32'd1);
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("lap_release_disp", {8'd0, o0[26:3]}, 32'h000500);
    check("lap_release_hold", {31'd0, o0[1]}, 32'd0);

    cur_tag = "both_btn";
    cyc(0, 1'b1, 1'b1, 1'b1);
    check("both_btn_disp", {8'd0, o0[26:3]}, 32'h000501);
    check("both_btn_flags", {29'd0, o0[2:0]}, 32'd0);
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("both_btn_clear", {5'd0, o0}, 32'd0);

    cur_tag = "overflow";
    cyc(1, 1'b1, 1'b0, 1'b0);
    ticks(1, 11999);
    check("ovf_max", {8'd0, o1[26:3]}, 32'h015999);
    check("ovf_not_yet", {31'd0, o1[0]}, 32'd0);
    ticks(1, 3);
    check("ovf_held", {8'd0, o1[26:3]}, 32'h015999);
    check("ovf_flag", {31'd0, o1[0]}, 32'd1);
    check("ovf_running", {31'd0, o1[2]}, 32'd1);
    cyc(1, 1'b1, 1'b0, 1'b0);
    cyc(1, 1'b0, 1'b1, 1'b0);
    check("ovf_cleared", {5'd0, o1}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
